load_store_ctrl: RTL and testbench
==================================

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 32, data width (32 or 64).
REQ-002 SHALL have parameter ADDR_W, 32, byte-address width.
REQ-003 SHALL have port clk input 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst input 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid input 1, request present.
REQ-006 SHALL have port req_ready output 1, high only in IDLE.
REQ-007 SHALL have port req_opcode input 7, 0000011 load, 0100011 store.
REQ-008 SHALL have port req_func3 input 3, RV size/sign field.
REQ-009 SHALL have port req_addr input ADDR_W, byte address.
REQ-010 SHALL have port req_wdata input XLEN, store data, right-aligned.
REQ-011 SHALL have port resp_valid output 1, completion present.
REQ-012 SHALL have port resp_ready input 1, completion consumed.
REQ-013 SHALL have port resp_rdata output XLEN, extended load data (0 for stores and faults).
REQ-014 SHALL have port resp_fault output 1, illegal func3 or unsupported misalignment.
REQ-015 SHALL have port mem_cs output 1, active-low chip select.
REQ-016 SHALL have port mem_wr_en output 1, low = write, high = read.
REQ-017 SHALL have port mem_addr output ADDR_W, word-aligned address (low log2(XLEN/8) bits zero).
REQ-018 SHALL have port mem_mask output XLEN/8, byte lanes accessed.
REQ-019 SHALL have port mem_wdata output XLEN, lane-shifted store data.
REQ-020 SHALL have port mem_rdata input XLEN, read word, valid with mem_ack.
REQ-021 SHALL have port mem_ack input 1, access complete this cycle.

Function
REQ-022 SHALL implement FSM IDLE -> BEAT0 -> (BEAT1) -> RESP -> IDLE; request accepted on req_valid&&req_ready, latching all req_* fields.
REQ-023 SHALL drive mem_* from registers in BEAT0/BEAT1 only (mem_cs=1, mem_wr_en=1, mask=0 elsewhere), holding them stable until mem_ack.
REQ-024 SHALL decode sizes: func3 000/100 byte, 001/101 half, 010/110 word, 011 double; 1xx loads zero-extend, others sign-extend; stores accept only 000/001/010/(011).
REQ-025 SHALL fault on func3 011/110 when XLEN=32, func3 111 always, store func3 1xx, or opcode not load/store; faulting requests skip BEAT0 and go directly to RESP.
REQ-026 SHALL compute mem_mask = size-wide ones shifted by addr offset; mem_wdata = req_wdata shifted left by 8*offset.
REQ-027 SHALL treat an access as misaligned when offset+size > XLEN/8.
REQ-028 SHALL, in RESP, hold resp_valid=1 and stable resp_* until resp_ready; minimum latency is accept -> resp_valid in 2 cycles with mem_ack in the first BEAT0 cycle.
REQ-029 SHALL ignore mem_ack outside BEAT0/BEAT1.
REQ-030 SHALL compute second-beat address as mem_addr+XLEN/8 modulo 2^ADDR_W (wraps at top).

Reset
REQ-031 SHALL on rst return to IDLE, with resp_valid=0, resp_rdata=0, resp_fault=0, mem_cs=1, mem_wr_en=1, mem_mask=0, mem_addr=0, mem_wdata=0, and req_ready=1 in the following cycle.
REQ-032 SHALL abandon any in-flight beat on mid-operation rst; an ack arriving later is ignored.

Configuration
REQ-033 SHALL honour macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned accesses are split into BEAT0 (low lanes at aligned address) and BEAT1 (remaining lanes at next word), with load bytes merged before extension; when undefined, misaligned accesses fault with no memory access and BEAT1 is absent.

Verification
REQ-034 SHALL pass: LB addr 0x1001, mem_rdata 0x1280F0CD -> mem_mask 0010, resp_rdata 0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-035 SHALL pass: SH addr 0x2002, wdata 0x0000BEEF -> mem_cs=0, mem_wr_en=0, mem_addr 0x2000, mem_mask 1100, mem_wdata 0xBEEF0000.
REQ-036 SHALL pass (macro on): LW 0x3003, beat0 0x3000/1000 rdata 0xAA000000, beat1 0x3004/0111 rdata 0x00DDCCBB -> resp_rdata 0xDDCCBBAA; macro off -> resp_fault=1, mem_cs never low.
REQ-037 SHALL pass: resp_ready low 3 cycles -> resp_valid/resp_rdata stable, req_ready=0 throughout.
REQ-038 SHALL pass: rst asserted while BEAT0 awaits ack -> next cycle mem_cs=1, req_ready=1, no resp_valid.
REQ-039 SHALL pass: XLEN=32, load func3 011 -> resp_fault=1, resp_rdata 0, no memory access.

Source files
------------

// File: rtl/load_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : load_store_ctrl
// Purpose  : RISC-V style load/store unit front end. It decodes size and sign,
//            builds byte-lane masks, lane-shifts store data and extends load
//            data. It also sequences one or two memory beats per request.
// Options  : LSU_MISALIGN_SPLIT_EN - when defined, a word-crossing access is
//            split into two beats. Otherwise it is reported as a fault.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [6:0]          req_opcode,
    input  logic [2:0]          req_func3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_fault,
    output logic                mem_cs,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_mask,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_store;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic              r_mem_cs;
    logic              r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NB-1:0]     r_mem_mask;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              r_resp_valid;
    logic              r_resp_fault;
    logic [XLEN-1:0]   r_resp_rdata;

    logic              w_is_load;
    logic              w_is_store;
    logic [OFF_W-1:0]  w_off;
    logic [2*NB-1:0]   w_ones;
    logic [2*NB-1:0]   w_mask_full;
    logic              w_misaligned;
    logic              w_mis_fault;
    logic              w_fault;
    logic [ADDR_W-1:0] w_word_addr;
    logic [XLEN-1:0]   w_rd_aligned;
    logic [XLEN-1:0]   w_load_data;
    logic              w_done;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;
    assign mem_cs     = r_mem_cs;
    assign mem_wr_en  = r_mem_wr_en;
    assign mem_addr   = r_mem_addr;
    assign mem_mask   = r_mem_mask;
    assign mem_wdata  = r_mem_wdata;

    assign w_is_load   = (req_opcode == 7'b0000011);
    assign w_is_store  = (req_opcode == 7'b0100011);
    assign w_off       = req_addr[OFF_W-1:0];
    assign w_word_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Size-wide run of ones; the double-width shift exposes lanes spilling into the next word
    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 2*NB; i++) begin
            w_ones[i] = (i < (32'd1 << req_func3[1:0]));
        end
    end

    assign w_mask_full  = w_ones << w_off;
    assign w_misaligned = |w_mask_full[2*NB-1:NB];

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              r_split;
    logic [NB-1:0]     r_mask1;
    logic [XLEN-1:0]   r_wdata1;
    logic [XLEN-1:0]   r_rd_lo;
    logic [2*XLEN-1:0] w_wdata_full;
    logic [2*XLEN-1:0] w_rd_cat;
    logic              w_next_beat;

    assign w_mis_fault  = 1'b0;
    assign w_wdata_full = {{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000};
    // Second beat supplies the upper bytes; merge before shifting down
    assign w_rd_cat     = (r_state == S_BEAT1) ? {mem_rdata, r_rd_lo}
                                               : {{XLEN{1'b0}}, mem_rdata};
    assign w_rd_aligned = XLEN'(w_rd_cat >> {r_off, 3'b000});
    assign w_next_beat  = mem_ack && (r_state == S_BEAT0) && r_split;
    assign w_done       = mem_ack && ((r_state == S_BEAT1) ||
                                      ((r_state == S_BEAT0) && !r_split));
`else
    logic [XLEN-1:0]   w_wdata_sh;

    assign w_mis_fault  = w_misaligned;
    assign w_wdata_sh   = req_wdata << {w_off, 3'b000};
    assign w_rd_aligned = mem_rdata >> {r_off, 3'b000};
    assign w_done       = mem_ack && ((r_state == S_BEAT0) || (r_state == S_BEAT1));
`endif

    // Illegal encodings and unsupported sizes bypass memory entirely
    always_comb begin
        w_fault = 1'b0;
        if (!(w_is_load || w_is_store))                                     w_fault = 1'b1;
        if (req_func3 == 3'b111)                                            w_fault = 1'b1;
        if (w_is_store && req_func3[2])                                     w_fault = 1'b1;
        if ((XLEN == 32) && ((req_func3 == 3'b011) || (req_func3 == 3'b110))) w_fault = 1'b1;
        if (w_mis_fault)                                                    w_fault = 1'b1;
    end

    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] raw,
                                                 input logic [1:0]      size,
                                                 input logic            uns);
        logic [XLEN-1:0] ext;
        logic            sgn;
        int              bits;
        ext  = raw;
        sgn  = 1'b0;
        bits = 8 << size;
        if (size != 2'b11) begin
            sgn = !uns && raw[bits-1];
            for (int i = 0; i < XLEN; i++) begin
                if (i >= bits) ext[i] = sgn;
            end
        end
        return ext;
    endfunction

    assign w_load_data = f_extend(w_rd_aligned, r_size, r_uns);

    // Request sequencing: accept, drive beats until acked, then hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_store      <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= '0;
            r_mem_cs     <= 1'b1;
            r_mem_wr_en  <= 1'b1;
            r_mem_addr   <= '0;
            r_mem_mask   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split      <= 1'b0;
            r_mask1      <= '0;
            r_wdata1     <= '0;
            r_rd_lo      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store <= w_is_store;
                        r_uns   <= req_func3[2];
                        r_size  <= req_func3[1:0];
                        r_off   <= w_off;
                        if (w_fault) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= S_BEAT0;
                            r_mem_cs    <= 1'b0;
                            r_mem_wr_en <= !w_is_store;
                            r_mem_addr  <= w_word_addr;
                            r_mem_mask  <= w_mask_full[NB-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                            r_mem_wdata <= w_wdata_full[XLEN-1:0];
                            r_wdata1    <= w_wdata_full[2*XLEN-1:XLEN];
                            r_mask1     <= w_mask_full[2*NB-1:NB];
                            r_split     <= w_misaligned;
`else
                            r_mem_wdata <= w_wdata_sh;
`endif
                        end
                    end
                end
                S_BEAT0, S_BEAT1: begin
                    if (w_done) begin
                        r_state      <= S_RESP;
                        r_mem_cs     <= 1'b1;
                        r_mem_wr_en  <= 1'b1;
                        r_mem_addr   <= '0;
                        r_mem_mask   <= '0;
                        r_mem_wdata  <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= 1'b0;
                        r_resp_rdata <= r_store ? '0 : w_load_data;
                    end
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (w_next_beat) begin
                        r_state     <= S_BEAT1;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(NB);
                        r_mem_mask  <= r_mask1;
                        r_mem_wdata <= r_wdata1;
                        r_rd_lo     <= mem_rdata;
                    end
`endif
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_fault <= 1'b0;
                        r_resp_rdata <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_ctrl
// Purpose  : Directed self-checking bench for load_store_ctrl (XLEN=32).
//            Misaligned expectations follow LSU_MISALIGN_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_ctrl;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [6:0]        req_opcode;
    logic [2:0]        req_func3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_fault;
    logic              mem_cs;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN/8-1:0] mem_mask;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;

    int n_checks = 0;
    int n_errors = 0;
    int cs_low_cnt = 0;
    int cs_snap;

    load_store_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_cs     (mem_cs),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_mask   (mem_mask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with the memory selected, to prove "no access" cases
    always @(negedge clk) begin
        if (mem_cs === 1'b0) cs_low_cnt <= cs_low_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge; returns at the next negedge
    task automatic send(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_opcode = op;
        req_func3  = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Check the beat being driven, then acknowledge it with read data
    task automatic beat(input string tag, input logic wr, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] wd, input logic [31:0] rd);
        chk({tag, ".cs"},    mem_cs,    1'b0);
        chk({tag, ".wr_en"}, mem_wr_en, wr);
        chk({tag, ".addr"},  mem_addr,  a);
        chk({tag, ".mask"},  mem_mask,  m);
        if (!wr) chk({tag, ".wdata"}, mem_wdata, wd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    // Check the held response, consume it, and confirm return to idle
    task automatic resp(input string tag, input logic [31:0] rd, input logic flt);
        chk({tag, ".valid"}, resp_valid, 1'b1);
        chk({tag, ".rdata"}, resp_rdata, rd);
        chk({tag, ".fault"}, resp_fault, flt);
        chk({tag, ".cs_idle"}, mem_cs, 1'b1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".ready_after"}, req_ready, 1'b1);
        chk({tag, ".valid_after"}, resp_valid, 1'b0);
    endtask

    // Faulting request: no memory beat, response one cycle after accept
    task automatic fault_case(input string tag, input logic [6:0] op,
                              input logic [2:0] f3, input logic [31:0] a);
        cs_snap = cs_low_cnt;
        send(op, f3, a, 32'hFFFF_FFFF);
        resp(tag, 32'h0, 1'b1);
        chk({tag, ".no_access"}, 64'(cs_low_cnt - cs_snap), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_opcode = 7'd0;
        req_func3  = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst.req_ready",  req_ready,  1'b1);
        chk("rst.resp_valid", resp_valid, 1'b0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.resp_fault", resp_fault, 1'b0);
        chk("rst.mem_cs",     mem_cs,     1'b1);
        chk("rst.mem_wr_en",  mem_wr_en,  1'b1);
        chk("rst.mem_mask",   mem_mask,   4'h0);
        chk("rst.mem_addr",   mem_addr,   32'h0);
        chk("rst.mem_wdata",  mem_wdata,  32'h0);
        @(negedge clk);

        // Byte loads, signed and unsigned
        send(OP_LOAD, 3'b000, 32'h0000_1001, 32'h0);
        beat("lb", 1'b1, 32'h0000_1000, 4'b0010, 32'h0, 32'h1280_F0CD);
        resp("lb", 32'hFFFF_FFF0, 1'b0);
        send(OP_LOAD, 3'b100, 32'h0000_1001, 32'h0);
        beat("lbu", 1'b1, 32'h0000_1000, 4'b0010, 32'h0, 32'h1280_F0CD);
        resp("lbu", 32'h0000_00F0, 1'b0);

        // Stores
        send(OP_STORE, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
        beat("sh", 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_0000, 32'h0);
        resp("sh", 32'h0, 1'b0);
        send(OP_STORE, 3'b000, 32'h0000_0003, 32'h0000_005A);
        beat("sb", 1'b0, 32'h0000_0000, 4'b1000, 32'h5A00_0000, 32'h0);
        resp("sb", 32'h0, 1'b0);
        send(OP_STORE, 3'b010, 32'h0000_0010, 32'h1234_5678);
        beat("sw", 1'b0, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0);
        resp("sw", 32'h0, 1'b0);

        // Half and word loads
        send(OP_LOAD, 3'b101, 32'h0000_0002, 32'h0);
        beat("lhu", 1'b1, 32'h0000_0000, 4'b1100, 32'h0, 32'h8001_1234);
        resp("lhu", 32'h0000_8001, 1'b0);
        send(OP_LOAD, 3'b010, 32'h0000_5000, 32'h0);
        beat("lw", 1'b1, 32'h0000_5000, 4'b1111, 32'h0, 32'h8765_4321);
        resp("lw", 32'h8765_4321, 1'b0);

        // Response back-pressure: held stable, no new request accepted
        send(OP_LOAD, 3'b001, 32'h0000_0006, 32'h0);
        beat("lh", 1'b1, 32'h0000_0004, 4'b1100, 32'h0, 32'h8001_0000);
        for (int i = 0; i < 3; i++) begin
            chk("bp.valid",     resp_valid, 1'b1);
            chk("bp.rdata",     resp_rdata, 32'hFFFF_8001);
            chk("bp.req_ready", req_ready,  1'b0);
            @(negedge clk);
        end
        resp("lh", 32'hFFFF_8001, 1'b0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_SPLIT_EN
        send(OP_LOAD, 3'b010, 32'h0000_3003, 32'h0);
        beat("lw_mis.b0", 1'b1, 32'h0000_3000, 4'b1000, 32'h0, 32'hAA00_0000);
        beat("lw_mis.b1", 1'b1, 32'h0000_3004, 4'b0111, 32'h0, 32'h00DD_CCBB);
        resp("lw_mis", 32'hDDCC_BBAA, 1'b0);
        send(OP_STORE, 3'b001, 32'h0000_2003, 32'h0000_BEEF);
        beat("sh_mis.b0", 1'b0, 32'h0000_2000, 4'b1000, 32'hEF00_0000, 32'h0);
        beat("sh_mis.b1", 1'b0, 32'h0000_2004, 4'b0001, 32'h0000_00BE, 32'h0);
        resp("sh_mis", 32'h0, 1'b0);
        send(OP_LOAD, 3'b010, 32'hFFFF_FFFE, 32'h0);
        beat("lw_wrap.b0", 1'b1, 32'hFFFF_FFFC, 4'b1100, 32'h0, 32'h8877_0000);
        beat("lw_wrap.b1", 1'b1, 32'h0000_0000, 4'b0011, 32'h0, 32'h0000_2211);
        resp("lw_wrap", 32'h2211_8877, 1'b0);
`else
        fault_case("lw_mis",  OP_LOAD,  3'b010, 32'h0000_3003);
        fault_case("sh_mis",  OP_STORE, 3'b001, 32'h0000_2003);
        fault_case("lw_wrap", OP_LOAD,  3'b010, 32'hFFFF_FFFE);
`endif

        // Illegal encodings
        fault_case("ld32",   OP_LOAD,     3'b011, 32'h0000_0000);
        fault_case("lwu32",  OP_LOAD,     3'b110, 32'h0000_0000);
        fault_case("f3_111", OP_LOAD,     3'b111, 32'h0000_0000);
        fault_case("sbu",    OP_STORE,    3'b100, 32'h0000_0000);
        fault_case("bad_op", 7'b0110011,  3'b010, 32'h0000_0000);

        // Reset while a beat waits for ack, then a stale ack
        send(OP_LOAD, 3'b010, 32'h0000_4000, 32'h0);
        chk("mid_rst.beat0", mem_cs, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst.cs",        mem_cs,     1'b1);
        chk("mid_rst.req_ready", req_ready,  1'b1);
        chk("mid_rst.valid",     resp_valid, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ack   = 1'b0;
        chk("late_ack.valid",     resp_valid, 1'b0);
        chk("late_ack.req_ready", req_ready,  1'b1);
        chk("late_ack.cs",        mem_cs,     1'b1);

        // Unit still usable afterwards
        send(OP_LOAD, 3'b000, 32'h0000_0000, 32'h0);
        beat("lb0", 1'b1, 32'h0000_0000, 4'b0001, 32'h0, 32'h0000_007F);
        resp("lb0", 32'h0000_007F, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
